shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 114 +++++++++++
 tb/tb_shift_add_multiplier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one multiplicand bit per cycle.
// Define SHIFT_ADD_EARLY_TERM_EN to finish as soon as no multiplicand bits remain.
module single_bit_multiply #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] a_i,
  input  logic            bit_i,
  output logic [SIZE-1:0] pp_o
);
  assign pp_o = a_i & {SIZE{bit_i}};
endmodule

module shift_add_multiplier #(
  parameter int SIZE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplier,
  input  logic [SIZE-1:0]   multiplicand,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   mcand_q, mcand_d;
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [2*SIZE-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [SIZE-1:0]   pp;
  logic [2*SIZE-1:0] pp_sh;
  logic [2*SIZE-1:0] acc_sum;
  logic              last;

  single_bit_multiply #(
    .SIZE(SIZE)
  ) u_sbm (
    .a_i  (a_q),
    .bit_i(mcand_q[0]),
    .pp_o (pp)
  );

  assign pp_sh   = {{SIZE{1'b0}}, pp} << cnt_q;
  assign acc_sum = acc_q + pp_sh;

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // Remaining multiplicand bits all zero: further additions are no-ops.
  assign last = (cnt_q == CW'(SIZE - 1))
             || (mcand_q[SIZE-1:1] == '0);
`else
  assign last = (cnt_q == CW'(SIZE - 1));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplier;
          mcand_d = multiplicand;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          prod_d  = acc_sum;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed testbench for shift_add_multiplier (SIZE=5).
// Honours SHIFT_ADD_EARLY_TERM_EN when computing expected latencies.
module tb_shift_add_multiplier;
  localparam int SIZE = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  a;
  logic [4:0]  b;
  logic        busy;
  logic        done;
  logic [9:0]  product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .SIZE(SIZE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .multiplier  (a),
    .multiplicand(b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

`ifdef SHIFT_ADD_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic int exp_lat(input logic [4:0] bv);
    int l;
    l = SIZE;
    if (EARLY) begin
      l = 1;
      for (int i = 0; i < SIZE; i++)
        if (bv[i]) l = i + 1;
    end
    return l;
  endfunction

  always @(negedge clk) begin
    if (!rst && busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap busy=%b done=%b", busy, done);
    end
  end

  // Issue one op, scramble operands, poke start mid-run; stop at done cycle.
  task automatic do_op(input logic [4:0] av, input logic [4:0] bv,
                       output int nbusy, output logic sawdone);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av;
    b = ~bv;
    nbusy = 0;
    sawdone = 1'b0;
    for (int i = 0; i < 40 && !sawdone; i++) begin
      if (busy) nbusy++;
      if (done) sawdone = 1'b1;
      else begin
        start = (i == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [4:0] av,
                          input logic [4:0] bv, input logic [9:0] ep);
    int nb;
    logic sd;
    do_op(av, bv, nb, sd);
    checks++;
    if (!sd) begin
      errors++;
      $display("FAIL %s_timeout done never seen", nm);
    end
    checks++;
    if (nb !== exp_lat(bv)) begin
      errors++;
      $display("FAIL %s_latency got=%0d exp=%0d", nm, nb, exp_lat(bv));
    end
    checks++;
    if (product !== ep) begin
      errors++;
      $display("FAIL %s_product got=%0d exp=%0d", nm, product, ep);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse done=%b busy=%b exp 0/0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 5'd0;
    b = 5'd0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 10'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b product=%0d exp 0/0/0",
               busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    check_op("mul13x11", 5'd13, 5'd11, 10'd143);
  endtask

  task automatic test_hold();
    @(negedge clk);
    a = 5'd7;
    b = 5'd9;
    repeat (4) @(negedge clk);
    checks++;
    if (product !== 10'd143 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold product=%0d done=%b busy=%b exp 143/0/0",
               product, done, busy);
    end
  endtask

  task automatic test_max();
    check_op("mul31x31", 5'd31, 5'd31, 10'd961);
  endtask

  task automatic test_zero();
    check_op("mul27x0", 5'd27, 5'd0, 10'd0);
    check_op("mul1x16", 5'd1, 5'd16, 10'd16);
  endtask

  task automatic test_back_to_back();
    int t_done[$];
    int per;
    per = exp_lat(5'd7) + 2;
    @(negedge clk);
    a = 5'd19;
    b = 5'd7;
    start = 1'b1;
    for (int t = 0; t < 3 * per + 2; t++) begin
      @(negedge clk);
      if (done) begin
        t_done.push_back(t);
        checks++;
        if (product !== 10'd133) begin
          errors++;
          $display("FAIL b2b_product got=%0d exp=133", product);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (t_done.size() < 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp>=3", t_done.size());
    end else begin
      checks++;
      if (t_done[1] - t_done[0] !== per || t_done[2] - t_done[1] !== per) begin
        errors++;
        $display("FAIL b2b_interval got=%0d,%0d exp=%0d",
                 t_done[1] - t_done[0], t_done[2] - t_done[1], per);
      end
    end
    repeat (per + 1) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    a = 5'd13;
    b = 5'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 10'd0) begin
      errors++;
      $display("FAIL abort_async busy=%b done=%b product=%0d exp 0/0/0",
               busy, done, product);
    end
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done done pulse seen after abort");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_op("mul3x5", 5'd3, 5'd5, 10'd15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
